// File: rtl/axis_fraction_divider_arbiter.sv
// Round-robin arbiter sharing one fraction divider among NUM_REQ requesters; results routed back by ID.
// Optional per-requester statistics are enabled by defining DIVFRAC_ARB_STATS_EN.
module axis_fraction_divider_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int DIVISOR_WIDTH    = 32,
  parameter int DIVIDEND_WIDTH   = 32,
  parameter int FRACTIONAL_WIDTH = 16,
  parameter int MAX_OUTSTANDING  = 64,
  localparam int QW   = DIVIDEND_WIDTH + FRACTIONAL_WIDTH,
  localparam int ID_W = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ),
  localparam int DVA  = ((DIVISOR_WIDTH + 7) / 8) * 8,
  localparam int DDA  = ((DIVIDEND_WIDTH + 7) / 8) * 8,
  localparam int QA   = ((QW + 7) / 8) * 8
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               aclken,
  input  logic [NUM_REQ-1:0]                 s_req_tvalid,
  output logic [NUM_REQ-1:0]                 s_req_tready,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]   s_req_divisor,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]  s_req_dividend,
  output logic [NUM_REQ-1:0]                 m_res_tvalid,
  output logic [QW-1:0]                      m_res_tdata,
  output logic                               m_res_div_zero,
  output logic                               m_div_divisor_tvalid,
  output logic [DVA-1:0]                     m_div_divisor_tdata,
  output logic [ID_W-1:0]                    m_div_divisor_tuser,
  output logic                               m_div_dividend_tvalid,
  output logic [DDA-1:0]                     m_div_dividend_tdata,
  input  logic                               s_div_dout_tvalid,
  input  logic [QA-1:0]                      s_div_dout_tdata,
  input  logic [ID_W:0]                      s_div_dout_tuser,
  output logic [7:0]                         outstanding,
`ifdef DIVFRAC_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]              stat_issue_cnt,
  output logic [31:0]                        stat_zero_cnt,
`endif
  output logic                               idle
);

  localparam logic [7:0]      MAX_OS = 8'(MAX_OUTSTANDING);
  localparam logic [ID_W:0]   NREQ   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST   = ID_W'(NUM_REQ - 1);

  logic [DIVISOR_WIDTH-1:0]  divisor_arr  [NUM_REQ];
  logic [DIVIDEND_WIDTH-1:0] dividend_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign divisor_arr[gi]  = s_req_divisor[gi*DIVISOR_WIDTH +: DIVISOR_WIDTH];
    assign dividend_arr[gi] = s_req_dividend[gi*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
  end

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [7:0]         count_q, count_d;
  logic               div_tvalid_q, div_tvalid_d;
  logic [DVA-1:0]     divisor_q, divisor_d;
  logic [DDA-1:0]     dividend_q, dividend_d;
  logic [ID_W-1:0]    tuser_q, tuser_d;
  logic [NUM_REQ-1:0] res_tvalid_q, res_tvalid_d;
  logic [QW-1:0]      res_tdata_q, res_tdata_d;
  logic               res_dz_q, res_dz_d;

  logic               eligible, hs;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      idx_w;
  logic [ID_W-1:0]    rid;

  assign rid = s_div_dout_tuser[ID_W:1];

  // A returning result frees a slot in the same cycle, so it re-opens issue at the limit.
  always_comb begin
    eligible = aresetn && aclken && ((count_q < MAX_OS) || s_div_dout_tvalid);
    gnt      = '0;
    gnt_idx  = '0;
    hs       = 1'b0;
    idx_w    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_w = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx_w >= NREQ) idx_w = idx_w - NREQ;
      if (eligible && !hs && s_req_tvalid[idx_w[ID_W-1:0]]) begin
        gnt[idx_w[ID_W-1:0]] = 1'b1;
        gnt_idx              = idx_w[ID_W-1:0];
        hs                   = 1'b1;
      end
    end
  end

`ifdef DIVFRAC_ARB_STATS_EN
  logic [31:0] issue_cnt_q [NUM_REQ];
  logic [31:0] issue_cnt_d [NUM_REQ];
  logic [31:0] zero_cnt_q, zero_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    if (aclken) begin
      if (hs) issue_cnt_d[gnt_idx] = issue_cnt_q[gnt_idx] + 32'd1;
      if (s_div_dout_tvalid && s_div_dout_tuser[0]) zero_cnt_d = zero_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REQ; i++) issue_cnt_q[i] <= '0;
      zero_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    assign stat_issue_cnt[gi*32 +: 32] = issue_cnt_q[gi];
  end
  assign stat_zero_cnt = zero_cnt_q;
`endif

  always_comb begin
    ptr_d        = ptr_q;
    count_d      = count_q;
    div_tvalid_d = div_tvalid_q;
    divisor_d    = divisor_q;
    dividend_d   = dividend_q;
    tuser_d      = tuser_q;
    res_tvalid_d = res_tvalid_q;
    res_tdata_d  = res_tdata_q;
    res_dz_d     = res_dz_q;
    if (aclken) begin
      div_tvalid_d = hs;
      if (hs) begin
        divisor_d                       = '0;
        divisor_d[DIVISOR_WIDTH-1:0]    = divisor_arr[gnt_idx];
        dividend_d                      = '0;
        dividend_d[DIVIDEND_WIDTH-1:0]  = dividend_arr[gnt_idx];
        tuser_d                         = gnt_idx;
        ptr_d                           = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      end
      case ({hs, s_div_dout_tvalid})
        2'b10:   if (count_q < MAX_OS) count_d = count_q + 8'd1;
        2'b01:   if (count_q != 8'd0)  count_d = count_q - 8'd1;
        default: count_d = count_q;
      endcase
      // Results tagged with an out-of-range ID are dropped silently.
      res_tvalid_d = '0;
      if (s_div_dout_tvalid && ({1'b0, rid} < NREQ)) begin
        res_tvalid_d[rid] = 1'b1;
        res_tdata_d       = s_div_dout_tdata[QW-1:0];
        res_dz_d          = s_div_dout_tuser[0];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q        <= '0;
      count_q      <= '0;
      div_tvalid_q <= 1'b0;
      divisor_q    <= '0;
      dividend_q   <= '0;
      tuser_q      <= '0;
      res_tvalid_q <= '0;
      res_tdata_q  <= '0;
      res_dz_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      div_tvalid_q <= div_tvalid_d;
      divisor_q    <= divisor_d;
      dividend_q   <= dividend_d;
      tuser_q      <= tuser_d;
      res_tvalid_q <= res_tvalid_d;
      res_tdata_q  <= res_tdata_d;
      res_dz_q     <= res_dz_d;
    end
  end

  assign s_req_tready          = gnt;
  assign m_div_divisor_tvalid  = div_tvalid_q;
  assign m_div_dividend_tvalid = div_tvalid_q;
  assign m_div_divisor_tdata   = divisor_q;
  assign m_div_dividend_tdata  = dividend_q;
  assign m_div_divisor_tuser   = tuser_q;
  assign m_res_tvalid          = res_tvalid_q;
  assign m_res_tdata           = res_tdata_q;
  assign m_res_div_zero        = res_dz_q;
  assign outstanding           = count_q;
  assign idle                  = (count_q == 8'd0) && !div_tvalid_q;

endmodule

// File: tb/tb_axis_fraction_divider_arbiter.sv
// Bench for axis_fraction_divider_arbiter: fixed-latency in-order divider stand-in plus directed vectors.
module tb_axis_fraction_divider_arbiter;
  localparam int NR  = 4;
  localparam int MAX = 8;
  localparam int LAT = 3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          aclken = 1'b1;
  logic [3:0]    s_req_tvalid = '0;
  logic [3:0]    s_req_tready;
  logic [127:0]  s_req_divisor = '0;
  logic [127:0]  s_req_dividend = '0;
  logic [3:0]    m_res_tvalid;
  logic [47:0]   m_res_tdata;
  logic          m_res_div_zero;
  logic          m_div_divisor_tvalid;
  logic [31:0]   m_div_divisor_tdata;
  logic [1:0]    m_div_divisor_tuser;
  logic          m_div_dividend_tvalid;
  logic [31:0]   m_div_dividend_tdata;
  logic          s_div_dout_tvalid = 1'b0;
  logic [47:0]   s_div_dout_tdata = '0;
  logic [2:0]    s_div_dout_tuser = '0;
  logic [7:0]    outstanding;
  logic          idle;
`ifdef DIVFRAC_ARB_STATS_EN
  logic [127:0]  stat_issue_cnt;
  logic [31:0]   stat_zero_cnt;
`endif

  axis_fraction_divider_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MAX)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
    .s_req_divisor(s_req_divisor), .s_req_dividend(s_req_dividend),
    .m_res_tvalid(m_res_tvalid), .m_res_tdata(m_res_tdata), .m_res_div_zero(m_res_div_zero),
    .m_div_divisor_tvalid(m_div_divisor_tvalid), .m_div_divisor_tdata(m_div_divisor_tdata),
    .m_div_divisor_tuser(m_div_divisor_tuser), .m_div_dividend_tvalid(m_div_dividend_tvalid),
    .m_div_dividend_tdata(m_div_dividend_tdata), .s_div_dout_tvalid(s_div_dout_tvalid),
    .s_div_dout_tdata(s_div_dout_tdata), .s_div_dout_tuser(s_div_dout_tuser),
    .outstanding(outstanding),
`ifdef DIVFRAC_ARB_STATS_EN
    .stat_issue_cnt(stat_issue_cnt), .stat_zero_cnt(stat_zero_cnt),
`endif
    .idle(idle)
  );

  always #5 aclk = ~aclk;

  // Divider stand-in: in-order queue, result offered LAT enabled cycles after issue.
  typedef struct {logic [1:0] id; logic [47:0] q; logic dz; int t;} op_t;
  op_t mq[$];
  int  ecyc = 0;
  int  n_iss = 0;
  bit  hold_div = 1'b0;

  always @(posedge aclk) begin
    #1;
    if (!aresetn) begin
      mq.delete();
      s_div_dout_tvalid = 1'b0;
    end else if (aclken) begin
      op_t o;
      logic [63:0] num;
      ecyc++;
      if (s_div_dout_tvalid) void'(mq.pop_front());
      if (m_div_divisor_tvalid) begin
        num  = {16'd0, m_div_dividend_tdata, 16'd0};
        o.id = m_div_divisor_tuser;
        o.dz = (m_div_divisor_tdata == 32'd0);
        o.q  = o.dz ? 48'd0 : 48'(num / {32'd0, m_div_divisor_tdata});
        o.t  = ecyc;
        mq.push_back(o);
        n_iss++;
      end
      if (!hold_div && mq.size() > 0 && ecyc >= mq[0].t + LAT) begin
        s_div_dout_tvalid = 1'b1;
        s_div_dout_tdata  = mq[0].q;
        s_div_dout_tuser  = {mq[0].id, mq[0].dz};
      end else begin
        s_div_dout_tvalid = 1'b0;
      end
    end
  end

  // Result monitor
  int          n_res = 0;
  int          res_ids[$];
  logic [3:0]  last_tv;
  logic [47:0] last_td;
  logic        last_dz;

  always @(posedge aclk) begin
    #1;
    if (aresetn && aclken && m_res_tvalid != 4'd0) begin
      n_res++;
      last_tv = m_res_tvalid;
      last_td = m_res_tdata;
      last_dz = m_res_div_zero;
      for (int i = 0; i < NR; i++) if (m_res_tvalid[i]) res_ids.push_back(i);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic set_req(input int k, input logic [31:0] dv, input logic [31:0] dd);
    s_req_divisor[k*32 +: 32]  = dv;
    s_req_dividend[k*32 +: 32] = dd;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((outstanding != 8'd0 || !idle) && n < 60) begin
      tick();
      n++;
    end
    chk(nm, {63'd0, idle}, 64'd1);
    repeat (2) tick();
  endtask

  typedef struct {int req; logic [31:0] dv; logic [31:0] dd; logic [47:0] q; logic dz;} vec_t;
  vec_t vecs [6];

  initial begin
    int n, n0, r0;
    logic [3:0] snap_tv;
    logic [7:0] snap_os;
    logic [1:0] snap_tu;
    logic       snap_dv;

    vecs[0] = '{req: 2, dv: 32'd4,          dd: 32'd10,         q: 48'h028000,       dz: 1'b0};
    vecs[1] = '{req: 1, dv: 32'd0,          dd: 32'd5,          q: 48'h000000,       dz: 1'b1};
    vecs[2] = '{req: 0, dv: 32'd3,          dd: 32'd1,          q: 48'h005555,       dz: 1'b0};
    vecs[3] = '{req: 3, dv: 32'd1,          dd: 32'hFFFFFFFF,   q: 48'hFFFFFFFF0000, dz: 1'b0};
    vecs[4] = '{req: 0, dv: 32'hFFFFFFFF,   dd: 32'd1,          q: 48'h000000,       dz: 1'b0};
    vecs[5] = '{req: 3, dv: 32'd2,          dd: 32'd7,          q: 48'h038000,       dz: 1'b0};

    // Reset state, with requests already pending
    s_req_tvalid = 4'hF;
    repeat (3) tick();
    #1;
    chk("rst_tready", {60'd0, s_req_tready}, 64'd0);
    chk("rst_outstanding", {56'd0, outstanding}, 64'd0);
    chk("rst_idle", {63'd0, idle}, 64'd1);
    chk("rst_res_tvalid", {60'd0, m_res_tvalid}, 64'd0);
    chk("rst_res_tdata", {16'd0, m_res_tdata}, 64'd0);
    chk("rst_div_tvalid", {62'd0, m_div_divisor_tvalid, m_div_dividend_tvalid}, 64'd0);

    // Round robin with all requesters holding tvalid
    for (int k = 0; k < NR; k++) set_req(k, 32'(k + 1), 32'd100);
    res_ids.delete();
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr_tready_%0d", c), {60'd0, s_req_tready}, 64'(4'b0001 << (c % 4)));
      tick();
      chk($sformatf("rr_tuser_%0d", c), {61'd0, m_div_divisor_tvalid, m_div_divisor_tuser},
          64'(4 + (c % 4)));
      $display("rr issue %0d: tuser=%0d", c, m_div_divisor_tuser);
    end
    s_req_tvalid = 4'h0;
    drain("rr_drain");
    chk("rr_res_count", 64'(res_ids.size()), 64'd8);
    for (int i = 0; i < 8 && i < res_ids.size(); i++)
      chk($sformatf("rr_res_id_%0d", i), 64'(res_ids[i]), 64'(i % 4));

    // Table-driven single operations
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].req, vecs[v].dv, vecs[v].dd);
      s_req_tvalid = 4'(1 << vecs[v].req);
      n = 0;
      #1;
      while (!s_req_tready[vecs[v].req] && n < 10) begin
        tick();
        #1;
        n++;
      end
      chk($sformatf("v%0d_grant", v), {60'd0, s_req_tready}, 64'(1 << vecs[v].req));
      n0 = n_res;
      tick();
      s_req_tvalid = 4'h0;
      chk($sformatf("v%0d_tuser", v), {62'd0, m_div_divisor_tuser}, 64'(vecs[v].req));
      chk($sformatf("v%0d_divisor", v), {32'd0, m_div_divisor_tdata}, {32'd0, vecs[v].dv});
      chk($sformatf("v%0d_dividend", v), {32'd0, m_div_dividend_tdata}, {32'd0, vecs[v].dd});
      n = 0;
      while (n_res == n0 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("v%0d_res_seen", v), 64'(n_res - n0), 64'd1);
      chk($sformatf("v%0d_res_tvalid", v), {60'd0, last_tv}, 64'(1 << vecs[v].req));
      chk($sformatf("v%0d_res_tdata", v), {16'd0, last_td}, {16'd0, vecs[v].q});
      chk($sformatf("v%0d_res_dz", v), {63'd0, last_dz}, {63'd0, vecs[v].dz});
      $display("vec %0d: req=%0d dv=%0h dd=%0h -> q=%0h dz=%0b", v, vecs[v].req,
               vecs[v].dv, vecs[v].dd, last_td, last_dz);
      tick();
      chk($sformatf("v%0d_strobe_once", v), {60'd0, m_res_tvalid}, 64'd0);
    end
    drain("vec_drain");

    // Throttle at MAX outstanding with the divider stalled
    hold_div = 1'b1;
    n0 = n_iss;
    s_req_tvalid = 4'hF;
    n = 0;
    while (n_iss - n0 < MAX && n < 30) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("thr_issued", 64'(n_iss - n0), 64'(MAX));
    chk("thr_outstanding", {56'd0, outstanding}, 64'(MAX));
    #1;
    chk("thr_tready_low", {60'd0, s_req_tready}, 64'd0);
    hold_div = 1'b0;
    tick();
    #1;
    chk("thr_regrant_onehot", {63'd0, $onehot(s_req_tready)}, 64'd1);
    tick();
    chk("thr_outstanding_same", {56'd0, outstanding}, 64'(MAX));
    chk("thr_result_routed", {63'd0, (m_res_tvalid != 4'd0)}, 64'd1);
    $display("throttle: issued=%0d outstanding=%0d", n_iss - n0, outstanding);
    s_req_tvalid = 4'h0;
    drain("thr_drain");

    // Clock-enable low for 5 cycles mid-stream
    n0 = n_iss;
    r0 = n_res;
    s_req_tvalid = 4'hF;
    repeat (6) tick();
    aclken = 1'b0;
    snap_tv = m_res_tvalid;
    snap_os = outstanding;
    snap_tu = m_div_divisor_tuser;
    snap_dv = m_div_divisor_tvalid;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("en_tready_%0d", c), {60'd0, s_req_tready}, 64'd0);
      tick();
      chk($sformatf("en_hold_%0d", c), {49'd0, snap_tv, snap_os, snap_tu, snap_dv},
          {49'd0, m_res_tvalid, outstanding, m_div_divisor_tuser, m_div_divisor_tvalid});
    end
    aclken = 1'b1;
    #1;
    chk("en_resume_onehot", {63'd0, $onehot(s_req_tready)}, 64'd1);
    tick();
    s_req_tvalid = 4'h0;
    drain("en_drain");
    chk("en_no_loss", 64'(n_res - r0), 64'(n_iss - n0));
    $display("enable: issued=%0d results=%0d", n_iss - n0, n_res - r0);

    // Reset with operations in flight
    hold_div = 1'b1;
    n0 = n_iss;
    set_req(0, 32'd5, 32'd9);
    s_req_tvalid = 4'b0001;
    n = 0;
    while (n_iss - n0 < 5 && n < 30) begin
      tick();
      n++;
    end
    s_req_tvalid = 4'h0;
    chk("rst5_outstanding", {56'd0, outstanding}, 64'd5);
    aresetn = 1'b0;
    s_req_tvalid = 4'hF;
    #1;
    chk("rst5_tready", {60'd0, s_req_tready}, 64'd0);
    tick();
    chk("rst5_outstanding_clr", {56'd0, outstanding}, 64'd0);
    chk("rst5_idle", {63'd0, idle}, 64'd1);
    chk("rst5_div_tvalid", {63'd0, m_div_divisor_tvalid}, 64'd0);
    s_req_tvalid = 4'h0;
    aresetn = 1'b1;
    hold_div = 1'b0;
    r0 = n_res;
    repeat (15) tick();
    chk("rst5_no_result", 64'(n_res - r0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
